// File: rtl/seg595_scan_ctrl.sv
// seg595_scan_ctrl: 6-digit 7-segment scan scheduler serialising {sel[5:0], seg[7:0]} frames into a 74HC595 chain.
// Build option LEADING_ZERO_BLANK_EN blanks zero digits above the most-significant nonzero digit.
module seg595_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int SCAN_CYC = 50000,
  parameter int DIGITS   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] bcd,
  input  logic [5:0]  dp,
  output logic        stcp,
  output logic        shcp,
  output logic        ds,
  output logic        oe
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int CW = $clog2(SCAN_CYC);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;
  state_t state;
  logic [2:0] idx;
  logic [3:0] bit_cnt;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [23:0] bcd_q;
  logic [5:0] dp_q;
  logic [12:0] sr;
  logic [23:0] src_bcd;
  logic [5:0] src_dp;
  logic [3:0] dig;
  logic [6:0] pat;
  logic blank;
  logic [13:0] frame;
  // digit 0 takes the live inputs so the whole refresh comes from the sample taken in that LOAD
  assign src_bcd = idx == 3'd0 ? bcd : bcd_q;
  assign src_dp = idx == 3'd0 ? dp : dp_q;
  assign dig = src_bcd[{idx, 2'b00} +: 4];
  always_comb
    case (dig)
      4'd0: pat = 7'h40;
      4'd1: pat = 7'h79;
      4'd2: pat = 7'h24;
      4'd3: pat = 7'h30;
      4'd4: pat = 7'h19;
      4'd5: pat = 7'h12;
      4'd6: pat = 7'h02;
      4'd7: pat = 7'h78;
      4'd8: pat = 7'h00;
      4'd9: pat = 7'h10;
      default: pat = 7'h7F;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] nz;
  always_comb
    for (int k = 0; k < 6; k++) nz[k] = |src_bcd[4*k +: 4];
  assign blank = idx != 3'd0 && (nz >> idx) == 6'd0;
`else
  assign blank = 1'b0;
`endif
  assign frame = {6'b000001 << idx, ~src_dp[idx], blank ? 7'h7F : pat};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      div <= '0;
      bit_cnt <= '0;
      sr <= '0;
      bcd_q <= '0;
      dp_q <= '0;
      stcp <= 1'b0;
      shcp <= 1'b0;
      ds <= 1'b0;
      oe <= 1'b1;
    end else begin
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          oe <= 1'b1;
          stcp <= 1'b0;
          shcp <= 1'b0;
          ds <= 1'b0;
          if (en) state <= LOAD;
        end
        LOAD: begin
          if (idx == 3'd0) begin
            bcd_q <= bcd;
            dp_q <= dp;
          end
          sr <= frame[12:0];
          ds <= frame[13];
          shcp <= 1'b0;
          div <= '0;
          bit_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          div <= div + 1'b1;
          if (div == DW'(CLK_DIV - 1)) shcp <= 1'b1;
          if (div == DW'(2 * CLK_DIV - 1)) begin
            div <= '0;
            shcp <= 1'b0;
            if (bit_cnt == 4'd13) begin
              stcp <= 1'b1;
              state <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ds <= sr[12];
              sr <= {sr[11:0], 1'b0};
            end
          end
        end
        LATCH: begin
          div <= div + 1'b1;
          if (div == DW'(CLK_DIV - 1)) begin
            stcp <= 1'b0;
            ds <= 1'b0;
            oe <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD:
          if (cnt == CW'(SCAN_CYC - 1)) begin
            idx <= idx == 3'(DIGITS - 1) ? 3'd0 : idx + 3'd1;
            if (en) begin
              cnt <= '0;
              state <= LOAD;
            end else begin
              oe <= 1'b1;
              state <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seg595_scan_ctrl.sv
// tb_seg595_scan_ctrl: random scoreboard bench for seg595_scan_ctrl; frames are predicted from the digit/decode rules
// and compared against frames reassembled from ds at each shcp rise. Honours LEADING_ZERO_BLANK_EN.
module tb_seg595_scan_ctrl;
  localparam int CLK_DIV = 2;
  localparam int SCAN_CYC = 120;
  localparam int DIGITS = 6;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [23:0] bcd = '0;
  logic [5:0] dp = '0;
  logic stcp, shcp, ds, oe;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int frames_seen = 0, bits_seen = 0, shcp_total = 0;
  logic [13:0] exp_q[$];
  logic [13:0] last_frame = '0;
  int m_idx = 0;
  logic [23:0] m_b = '0;
  logic [5:0] m_d = '0;

  seg595_scan_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_CYC(SCAN_CYC), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bcd(bcd), .dp(dp),
    .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg7(input int v);
    logic [6:0] t[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return v < 10 ? t[v] : 7'h7F;
  endfunction

  function automatic logic [13:0] model_frame(input int k, input logic [23:0] b, input logic [5:0] d);
    int v = int'((b >> (4 * k)) & 24'hF);
    logic [6:0] p = seg7(v);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (b >> (4 * k)) == 24'd0) p = 7'h7F;
`endif
    return {6'(1 << k), ~d[k], p};
  endfunction

  // reference: digit slots advance 0..5 cyclically; inputs are sampled whenever digit 0 is sent
  task automatic plan(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_idx == 0) begin
        m_b = bcd;
        m_d = dp;
      end
      exp_q.push_back(model_frame(m_idx, m_b, m_d));
      m_idx = (m_idx + 1) % DIGITS;
    end
  endtask

  initial begin : monitor
    logic p_shcp, p_stcp;
    logic [13:0] acc;
    int last_rise, last_stcp;
    p_shcp = 1'b0;
    p_stcp = 1'b0;
    acc = '0;
    last_rise = 0;
    last_stcp = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = '0;
        bits_seen = 0;
        p_shcp = 1'b0;
        p_stcp = 1'b0;
        last_stcp = -1;
      end else begin
        if (shcp && !p_shcp) begin
          if (bits_seen > 0) check("shcp_period", cyc - last_rise, 2 * CLK_DIV);
          last_rise = cyc;
          acc = {acc[12:0], ds};
          bits_seen++;
          shcp_total++;
        end
        if (!shcp && p_shcp) check("shcp_high", cyc - last_rise, CLK_DIV);
        if (stcp && !p_stcp) begin
          check("bits_per_frame", bits_seen, 14);
          if (!oe && last_stcp >= 0) check("stcp_period", cyc - last_stcp, SCAN_CYC);
          last_stcp = cyc;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h, expected no frame", acc);
          end else check("frame", acc, exp_q.pop_front());
          last_frame = acc;
          frames_seen++;
          bits_seen = 0;
        end
        if (!stcp && p_stcp) begin
          check("stcp_width", cyc - last_stcp, CLK_DIV);
          check("oe_after_latch", oe, 1'b0);
        end
        p_shcp = shcp;
        p_stcp = stcp;
      end
    end
  end

  task automatic wait_frames(input string name, input int target, input int min_bits);
    int t = 0;
    int lim = 16 * SCAN_CYC;
    while (!(frames_seen >= target && bits_seen >= min_bits) && t < lim) begin
      @(negedge clk);
      t++;
    end
    check(name, t < lim, 1'b1);
  endtask

  // n frames; after frame j (j>0) switch inputs to nb/nd; drop en at bit `drop` of the last frame
  task automatic run(input int n, input int j, input int drop, input logic [23:0] nb, input logic [5:0] nd);
    int f0, r0, t;
    f0 = frames_seen;
    plan(j == 0 ? n : j);
    @(negedge clk);
    en = 1'b1;
    if (j != 0) begin
      wait_frames("timeout_mid", f0 + j, 0);
      bcd = nb;
      dp = nd;
      plan(n - j);
    end
    wait_frames("timeout_drop", f0 + n - 1, drop);
    en = 1'b0;
    t = 0;
    while (!(frames_seen >= f0 + n && oe) && t < 4 * SCAN_CYC) begin
      @(negedge clk);
      t++;
    end
    check("timeout_stop", t < 4 * SCAN_CYC, 1'b1);
    r0 = shcp_total;
    repeat (2 * SCAN_CYC) @(negedge clk);
    check("frames_in_run", frames_seen - f0, n);
    check("queue_drained", exp_q.size(), 0);
    check("no_shcp_after_stop", shcp_total - r0, 0);
    check("idle_oe", oe, 1'b1);
    check("idle_stcp", stcp, 1'b0);
  endtask

  task automatic rst_mid(input int k);
    int f0;
    f0 = frames_seen;
    plan(k);
    @(negedge clk);
    en = 1'b1;
    wait_frames("timeout_rst", f0 + k - 1, 7);
    rst_n = 1'b0;
    en = 1'b0;
    exp_q.delete();
    m_idx = 0;
    #1;
    check("async_rst_shcp", shcp, 1'b0);
    check("async_rst_stcp", stcp, 1'b0);
    check("async_rst_ds", ds, 1'b0);
    check("async_rst_oe", oe, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r0, nd;
    logic [23:0] b;
    repeat (5) @(posedge clk);
    #1;
    check("rst_stcp", stcp, 1'b0);
    check("rst_shcp", shcp, 1'b0);
    check("rst_ds", ds, 1'b0);
    check("rst_oe", oe, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = shcp_total;
    repeat (10000) @(negedge clk);
    check("idle_no_shcp", shcp_total - r0, 0);
    check("idle_oe_released", oe, 1'b1);
    bcd = 24'h000007;
    dp = 6'd0;
    run(1, 0, 5, bcd, dp);
    check("first_frame_literal", last_frame, 14'h01F8);
    bcd = 24'h00F123;
    dp = 6'b000100;
    run(12, 0, 9, bcd, dp);
    run(4, 2, 5, 24'h000042, 6'b000001);
    rst_mid(3);
    bcd = 24'h000042;
    dp = 6'd0;
    run(6, 0, 14, bcd, dp);
    for (int it = 0; it < 12; it++) begin
      nd = $urandom_range(1, 6);
      b = '0;
      for (int k = 0; k < 6; k++) if (k < nd) b[4*k +: 4] = 4'($urandom_range(0, 15));
      if (it == 6) rst_mid($urandom_range(1, 8));
      nd = $urandom_range(1, 9);
      run(nd, $urandom_range(0, nd - 1), $urandom_range(1, 14), b, 6'($urandom));
      bcd = 24'($urandom) & b;
      dp = 6'($urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, expected finish before cycle 80000");
    $fatal(1, "watchdog");
  end
endmodule
